if_fetch: RTL
=============

Name: if_fetch

Overview:
Instruction fetch stage; it feeds the decode stage through the inst/pc pipeline interface. Keeps the PC and runs a single-outstanding req/ack handshake with instruction memory. Inserts NOP bubbles when no instruction is ready, holds its output under downstream stall, and redirects on a branch, discarding any in-flight fetch.

Parameters:
W_PC, 16, PC / instruction-memory word-address width
W_INST, 32, instruction width
RESET_PC, 16'h0000, first fetch address after reset
NOP_INST, 32'h3C00_0000, bubble instruction (opcode 7'b001_1110, all other fields 0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
stall_i  in  1  stall from decode stage (1: hold output)
br_taken_i  in  1  branch redirect pulse
br_addr_i  in  W_PC  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  W_PC  fetch address; stable while imem_req_o=1
imem_data_i  in  W_INST  fetched word; valid when imem_ack_i=1
imem_ack_i  in  1  completes a request (may be high in the same cycle as req)
inst_o  out  W_INST  instruction to decode stage
pc_value_o  out  W_PC  address of inst_o
fetch_busy_o  out  1  request outstanding or buffer full

Behaviour:
- Registers: pc_r, state, kill_r, buf_valid/buf_inst/buf_pc, inst_o, pc_value_o. All outputs are registered.
- Reset (rst=0, async): state=S_IDLE, pc_r=RESET_PC, imem_req_o=0, imem_addr_o=0, inst_o=NOP_INST, pc_value_o=0, kill_r=0, buf_valid=0, fetch_busy_o=0.
- A transfer completes on a posedge where imem_req_o=1 and imem_ack_i=1.
- State machine:
  - S_IDLE: next edge goes to S_REQ, with req=1 and addr=pc_r.
  - S_REQ, transfer completes, stall_i=0, kill_r=0: inst_o<=imem_data_i; pc_value_o<=imem_addr_o; pc_r and addr <= addr+1 (mod 2^W_PC, so FFFF->0000); req stays 1. This gives 1 instruction/cycle with a zero-wait memory.
  - S_REQ, no transfer completes, stall_i=0: inst_o<=NOP_INST, pc_value_o<=0 (bubble); addr and req hold.
  - S_REQ, transfer completes, stall_i=1: data and address go to the buffer; go to S_FULL; req<=0; pc_r advances; inst_o and pc_value_o hold.
  - S_REQ, no transfer completes, stall_i=1: inst_o and pc_value_o hold; req and addr hold.
  - S_FULL, stall_i=1: everything holds.
  - S_FULL, stall_i=0: inst_o<=buf_inst; pc_value_o<=buf_pc; buf_valid<=0; req<=1 with addr=pc_r; go to S_REQ.
- Branch (br_taken_i=1) takes priority over stall and over normal transfer completion:
  - pc_r<=br_addr_i; buffer cleared; inst_o<=NOP_INST; pc_value_o<=0.
  - req outstanding with no ack this cycle: kill_r<=1; addr keeps its old value until the ack. On that ack the data is discarded, kill_r<=0, and addr<=pc_r with req=1 on the next edge.
  - ack in the same cycle as the branch: data discarded; addr<=br_addr_i, req=1.
  - branch in S_FULL or S_IDLE: go to S_REQ with addr=br_addr_i.
- While kill_r=1, a further br_taken_i only updates pc_r.
- While kill_r=1, stall_i has no effect on discarding the killed data.
- fetch_busy_o = imem_req_o | buf_valid (registered form).
- Never more than one outstanding request.

Test Plan:
- Reset with rst=0 mid-transfer, then release -> all outputs at reset values; one cycle later req=1, addr=0000.
- Zero-wait memory (ack tied 1, data=addr|0x1000_0000) -> inst_o = 1000_0000, 1000_0001, … on consecutive cycles, pc_value_o = 0,1,2.
- Memory with 2 wait states -> two NOP_INST bubbles (pc_value_o=0) between instructions; addr held stable while req=1.
- stall_i=1 for 3 cycles while ack arrives for addr 5 -> inst_o frozen, req drops; after stall_i=0, inst_o = word 5 on the next edge and req resumes at addr 6.
- br_taken_i with br_addr_i=0x0040 while a request to addr 7 waits 2 cycles -> ack for 7 discarded, inst_o=NOP_INST, next req addr=0x0040 and its word appears with pc_value_o=0x0040.
- RESET_PC=16'hFFFE, zero-wait -> pc_value_o = FFFE, FFFF, 0000 (wrap).

Source files
------------

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Instruction-memory req/ack bus between the fetch stage
//               (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if #(
  parameter int W_PC   = 16,
  parameter int W_INST = 32
);
  logic              imem_req_o;
  logic [W_PC-1:0]   imem_addr_o;
  logic [W_INST-1:0] imem_data_i;
  logic              imem_ack_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_data_i,
    input  imem_ack_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_data_i,
    output imem_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage. Keeps the PC, runs a single
//               outstanding req/ack fetch, inserts NOP bubbles, buffers one
//               word under stall and redirects on branches (killing any
//               in-flight fetch).
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int                W_PC     = 16,
  parameter int                W_INST   = 32,
  parameter logic [W_PC-1:0]   RESET_PC = 16'h0000,
  parameter logic [W_INST-1:0] NOP_INST = 32'h3C00_0000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              stall_i,
  input  wire logic              br_taken_i,
  input  wire logic [W_PC-1:0]   br_addr_i,
  if_fetch_if.master             imem,
  output logic      [W_INST-1:0] inst_o,
  output logic      [W_PC-1:0]   pc_value_o,
  output logic                   fetch_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [W_PC-1:0]   pc_r, pc_nxt;
  logic              kill_r, kill_nxt;
  logic              buf_valid, buf_valid_nxt;
  logic [W_INST-1:0] buf_inst, buf_inst_nxt;
  logic [W_PC-1:0]   buf_pc, buf_pc_nxt;
  logic              req_r, req_nxt;
  logic [W_PC-1:0]   addr_r, addr_nxt;
  logic [W_INST-1:0] inst_r, inst_nxt;
  logic [W_PC-1:0]   pcv_r, pcv_nxt;
  logic              busy_r, busy_nxt;

  logic              xfer;
  logic [W_PC-1:0]   addr_inc;

  assign xfer     = req_r & imem.imem_ack_i;
  // Wraps modulo 2^W_PC naturally.
  assign addr_inc = addr_r + {{(W_PC-1){1'b0}}, 1'b1};

  assign imem.imem_req_o  = req_r;
  assign imem.imem_addr_o = addr_r;
  assign inst_o           = inst_r;
  assign pc_value_o       = pcv_r;
  assign fetch_busy_o     = busy_r;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc_r      <= RESET_PC;
      kill_r    <= 1'b0;
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= '0;
      req_r     <= 1'b0;
      addr_r    <= '0;
      inst_r    <= NOP_INST;
      pcv_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_r      <= pc_nxt;
      kill_r    <= kill_nxt;
      buf_valid <= buf_valid_nxt;
      buf_inst  <= buf_inst_nxt;
      buf_pc    <= buf_pc_nxt;
      req_r     <= req_nxt;
      addr_r    <= addr_nxt;
      inst_r    <= inst_nxt;
      pcv_r     <= pcv_nxt;
      busy_r    <= busy_nxt;
    end
  end

  // Next-state and next-output logic; branch beats kill beats normal flow.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_r;
    kill_nxt      = kill_r;
    buf_valid_nxt = buf_valid;
    buf_inst_nxt  = buf_inst;
    buf_pc_nxt    = buf_pc;
    req_nxt       = req_r;
    addr_nxt      = addr_r;
    inst_nxt      = inst_r;
    pcv_nxt       = pcv_r;

    if (br_taken_i) begin
      pc_nxt = br_addr_i;
      if (kill_r) begin
        // Already redirecting: just retarget; the pending ack is still junk.
        if (xfer) begin
          kill_nxt = 1'b0;
          addr_nxt = br_addr_i;
        end
      end else begin
        buf_valid_nxt = 1'b0;
        inst_nxt      = NOP_INST;
        pcv_nxt       = '0;
        state_nxt     = S_REQ;
        req_nxt       = 1'b1;
        // Address must stay stable until the outstanding request is acked.
        if (state == S_REQ && !xfer) begin
          kill_nxt = 1'b1;
        end else begin
          addr_nxt = br_addr_i;
        end
      end
    end else if (kill_r) begin
      if (!stall_i) begin
        inst_nxt = NOP_INST;
        pcv_nxt  = '0;
      end
      if (xfer) begin
        kill_nxt = 1'b0;
        addr_nxt = pc_r;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pc_r;
        end
        S_REQ: begin
          if (xfer) begin
            pc_nxt = addr_inc;
            if (!stall_i) begin
              inst_nxt = imem.imem_data_i;
              pcv_nxt  = addr_r;
              addr_nxt = addr_inc;
            end else begin
              buf_valid_nxt = 1'b1;
              buf_inst_nxt  = imem.imem_data_i;
              buf_pc_nxt    = addr_r;
              req_nxt       = 1'b0;
              state_nxt     = S_FULL;
            end
          end else if (!stall_i) begin
            inst_nxt = NOP_INST;
            pcv_nxt  = '0;
          end
        end
        S_FULL: begin
          if (!stall_i) begin
            inst_nxt      = buf_inst;
            pcv_nxt       = buf_pc;
            buf_valid_nxt = 1'b0;
            req_nxt       = 1'b1;
            addr_nxt      = pc_r;
            state_nxt     = S_REQ;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end

    busy_nxt = req_nxt | buf_valid_nxt;
  end

endmodule
`default_nettype wire
